// File: rtl/gshare_pkg.sv
// gshare_pkg: shared types and constants for the gshare predictor and its train tracker
package gshare_pkg;
  localparam int N = 7;
  typedef struct packed {
    logic [N-1:0] pc;
    logic         taken;
    logic [N-1:0] history;
  } pred_rec_t;
  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] LNT = 2'd1;
  localparam logic [1:0] LT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;
endpackage

// File: rtl/gshare_inflight_fifo.sv
// gshare_inflight_fifo: in-order queue of issued predictions with push/pop/flush
module gshare_inflight_fifo
  import gshare_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  pred_rec_t     din,
  output pred_rec_t     dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  pred_rec_t mem [DEPTH];
  logic [AW-1:0] head, tail;
  logic wr, rd;
  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;
  assign wr    = push && !full;
  assign rd    = pop && !empty;
  assign dout  = mem[head];
  always_ff @(posedge clk)
    if (wr) mem[tail] <= din;
  // flush drops the same-cycle push: everything behind the popped head is wrong-path
  always_ff @(posedge clk)
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush && rd) begin
      head  <= head + AW'(1);
      tail  <= head + AW'(1);
      count <= '0;
    end else begin
      if (wr) tail <= tail + AW'(1);
      if (rd) head <= head + AW'(1);
      count <= count + CW'(wr) - CW'(rd);
    end
endmodule

// File: rtl/gshare_train_tracker.sv
// gshare_train_tracker: queues predictions and emits registered train transactions; GSHARE_TRAIN_STATS_EN adds resolve/mispredict counters
module gshare_train_tracker
  import gshare_pkg::*;
#(
  parameter int N = 7,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         predict_valid,
  input  logic [N-1:0]                 predict_pc,
  input  logic                         predict_taken,
  input  logic [N-1:0]                 predict_history,
  output logic                         predict_ready,
  input  logic                         resolve_valid,
  input  logic                         resolve_taken,
  output logic                         resolve_ready,
  output logic                         train_valid,
  output logic                         train_taken,
  output logic                         train_mispredicted,
  output logic [N-1:0]                 train_history,
  output logic [N-1:0]                 train_pc,
`ifdef GSHARE_TRAIN_STATS_EN
  output logic [31:0]                  stat_resolved,
  output logic [31:0]                  stat_mispredicted,
`endif
  output logic [$clog2(DEPTH+1)-1:0]   inflight_count
);
  pred_rec_t head_rec;
  logic full, empty, accept, mis;
  assign accept        = resolve_valid && resolve_ready;
  assign mis           = head_rec.taken ^ resolve_taken;
  assign predict_ready = !full;
  assign resolve_ready = !empty;
  gshare_inflight_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (predict_valid),
    .pop   (accept),
    .flush (accept && mis),
    .din   ('{pc: predict_pc, taken: predict_taken, history: predict_history}),
    .dout  (head_rec),
    .full  (full),
    .empty (empty),
    .count (inflight_count)
  );
  always_ff @(posedge clk)
    if (reset) begin
      train_valid        <= 1'b0;
      train_taken        <= 1'b0;
      train_mispredicted <= 1'b0;
      train_history      <= '0;
      train_pc           <= '0;
    end else begin
      train_valid        <= accept;
      train_taken        <= accept && resolve_taken;
      train_mispredicted <= accept && mis;
      train_history      <= accept ? head_rec.history : '0;
      train_pc           <= accept ? head_rec.pc : '0;
    end
`ifdef GSHARE_TRAIN_STATS_EN
  always_ff @(posedge clk)
    if (reset) begin
      stat_resolved     <= '0;
      stat_mispredicted <= '0;
    end else begin
      stat_resolved     <= stat_resolved + 32'(train_valid);
      stat_mispredicted <= stat_mispredicted + 32'(train_valid && train_mispredicted);
    end
`endif
endmodule

// File: tb/tb_gshare_train_tracker.sv
// tb_gshare_train_tracker: scoreboard bench comparing train transactions and occupancy against a queue model
module tb_gshare_train_tracker;
  localparam int N = 7;
  localparam int DEPTH = 8;
  localparam int CW = $clog2(DEPTH + 1);
  typedef struct packed {
    logic [N-1:0] pc;
    logic         taken;
    logic [N-1:0] history;
  } rec_t;
  typedef struct packed {
    logic         v;
    logic         t;
    logic         m;
    logic [N-1:0] h;
    logic [N-1:0] p;
  } tr_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic predict_valid = 1'b0, predict_taken = 1'b0, resolve_valid = 1'b0, resolve_taken = 1'b0;
  logic [N-1:0] predict_pc = '0, predict_history = '0;
  logic predict_ready, resolve_ready, train_valid, train_taken, train_mispredicted;
  logic [N-1:0] train_history, train_pc;
  logic [CW-1:0] inflight_count;
`ifdef GSHARE_TRAIN_STATS_EN
  logic [31:0] stat_resolved, stat_mispredicted;
  int m_res = 0, m_mis = 0;
`endif
  rec_t model[$];
  tr_t exp_q[$];
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  gshare_train_tracker #(.N(N), .DEPTH(DEPTH)) dut (
    .clk                (clk),
    .reset              (reset),
    .predict_valid      (predict_valid),
    .predict_pc         (predict_pc),
    .predict_taken      (predict_taken),
    .predict_history    (predict_history),
    .predict_ready      (predict_ready),
    .resolve_valid      (resolve_valid),
    .resolve_taken      (resolve_taken),
    .resolve_ready      (resolve_ready),
    .train_valid        (train_valid),
    .train_taken        (train_taken),
    .train_mispredicted (train_mispredicted),
    .train_history      (train_history),
    .train_pc           (train_pc),
`ifdef GSHARE_TRAIN_STATS_EN
    .stat_resolved      (stat_resolved),
    .stat_mispredicted  (stat_mispredicted),
`endif
    .inflight_count     (inflight_count)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask
  task automatic step(input logic rst, input logic pv, input logic [N-1:0] pc, input logic pt,
                      input logic [N-1:0] ph, input logic rv, input logic rt);
    tr_t e;
    rec_t f;
    logic push_ok, pop_ok;
    reset = rst;
    predict_valid = pv;
    predict_pc = pc;
    predict_taken = pt;
    predict_history = ph;
    resolve_valid = rv;
    resolve_taken = rt;
    e = '0;
    push_ok = pv && (model.size() < DEPTH);
    pop_ok = rv && (model.size() > 0);
    if (rst) model.delete();
    else begin
      if (pop_ok) begin
        f = model.pop_front();
        e = '{v: 1'b1, t: rt, m: f.taken ^ rt, h: f.history, p: f.pc};
      end
      if (pop_ok && e.m) model.delete();
      else if (push_ok) begin
        f = '{pc: pc, taken: pt, history: ph};
        model.push_back(f);
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("train", 32'({train_valid, train_taken, train_mispredicted, train_history, train_pc}), 32'(e));
    chk("count", 32'(inflight_count), 32'(model.size()));
    chk("predict_ready", 32'(predict_ready), 32'(model.size() < DEPTH));
    chk("resolve_ready", 32'(resolve_ready), 32'(model.size() > 0));
`ifdef GSHARE_TRAIN_STATS_EN
    if (rst) begin
      m_res = 0;
      m_mis = 0;
    end
    chk("stat_resolved", stat_resolved, 32'(m_res));
    chk("stat_mispredicted", stat_mispredicted, 32'(m_mis));
    m_res += int'(e.v);
    m_mis += int'(e.v && e.m);
`endif
  endtask
  task automatic idle();
    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask
  task automatic push(input logic [N-1:0] pc, input logic pt, input logic [N-1:0] ph);
    step(1'b0, 1'b1, pc, pt, ph, 1'b0, 1'b0);
  endtask
  task automatic resolve(input logic rt);
    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, rt);
  endtask
  initial begin
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 7'h11, 1'b1, 7'h22, 1'b1, 1'b1);
    repeat (3) idle();
    push(7'h0a, 1'b1, 7'h00);
    resolve(1'b1);
    idle();
    push(7'h01, 1'b0, 7'h31);
    push(7'h02, 1'b0, 7'h32);
    push(7'h03, 1'b0, 7'h33);
    resolve(1'b1);
    resolve(1'b1);
    idle();
    for (int i = 0; i < DEPTH; i++) push(7'(8'h10 + i), i[0], 7'(8'h40 + i));
    push(7'h7f, 1'b1, 7'h7e);
    step(1'b0, 1'b1, 7'h6f, 1'b0, 7'h6e, 1'b1, model[0].taken);
    step(1'b0, 1'b1, 7'h5f, 1'b1, 7'h5e, 1'b1, model[0].taken);
    for (int i = 0; i < 2 * DEPTH && model.size() > 0; i++) resolve(model[0].taken);
    resolve(1'b0);
    for (int i = 0; i < 5; i++) push(7'(8'h20 + i), 1'b1, 7'(8'h50 + i));
    step(1'b1, 1'b1, 7'h2f, 1'b1, 7'h5f, 1'b1, 1'b1);
    idle();
    for (int i = 0; i < 60; i++)
      step(1'b0, 1'($urandom_range(0, 3) != 0), 7'($urandom), 1'($urandom), 7'($urandom),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) != 0));
    for (int i = 0; i < 2 * DEPTH && model.size() > 0; i++) resolve(model[0].taken);
    idle();
    idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
